// File: rtl/dsp_wb_master.sv
// Wishbone classic master for the DSP file state machine.
// One outstanding request, with retry, timeout and sticky error.
module dsp_wb_master #(
  parameter int              dw        = 32,
  parameter int              aw        = 32,
  parameter int              TIMEOUT   = 1000,
  parameter int              MAX_RETRY = 3,
  parameter logic [dw-1:0]   ERR_DATA  = 'hDEAD_BEEF
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [aw-1:0] address,
  input  logic          start,
  input  logic [3:0]    selection,
  input  logic          write,
  input  logic [dw-1:0] data_wr,
  output logic [dw-1:0] data_rd,
  output logic          active,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  input  logic          clear_error,
  output logic          bus_error,
  output logic [aw-1:0] err_addr
);

  localparam int RW =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic          TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RETRY,
    S_RELEASE
  } state_t;

  state_t        r_state;
  logic [aw-1:0] r_adr;
  logic [dw-1:0] r_dat;
  logic [3:0]    r_sel;
  logic          r_we;
  logic          r_cyc;
  logic          r_active;
  logic [dw-1:0] r_data_rd;
  logic [RW-1:0] r_rty_cnt;
  logic [15:0]   r_tmo_cnt;
  logic          r_bus_error;
  logic [aw-1:0] r_err_addr;

  state_t        w_state;
  logic [aw-1:0] w_adr;
  logic [dw-1:0] w_dat;
  logic [3:0]    w_sel;
  logic          w_we;
  logic          w_cyc;
  logic          w_active;
  logic [dw-1:0] w_data_rd;
  logic [RW-1:0] w_rty_cnt;
  logic [15:0]   w_tmo_cnt;
  logic          w_bus_error;
  logic [aw-1:0] w_err_addr;
  logic          w_abort;

  // Next-state and next-output logic; abort overrides the case result.
  always_comb begin
    w_state     = r_state;
    w_adr       = r_adr;
    w_dat       = r_dat;
    w_sel       = r_sel;
    w_we        = r_we;
    w_cyc       = r_cyc;
    w_active    = r_active;
    w_data_rd   = r_data_rd;
    w_rty_cnt   = r_rty_cnt;
    w_tmo_cnt   = r_tmo_cnt;
    w_bus_error = r_bus_error;
    w_err_addr  = r_err_addr;
    w_abort     = 1'b0;

    if (clear_error)
      w_bus_error = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_adr     = address;
          w_dat     = data_wr;
          w_sel     = selection;
          w_we      = write;
          w_cyc     = 1'b1;
          w_active  = 1'b1;
          w_rty_cnt = '0;
          w_tmo_cnt = '0;
          w_state   = S_BUS;
        end
      end
      S_BUS: begin
        if (wb_err_i) begin
          w_abort = 1'b1;
        end else if (wb_rty_i) begin
          w_cyc = 1'b0;
          if (r_rty_cnt == RTY_LAST) begin
            w_abort = 1'b1;
          end else begin
            w_rty_cnt = r_rty_cnt + 1'b1;
            w_state   = S_RETRY;
          end
        end else if (wb_ack_i) begin
          w_cyc    = 1'b0;
          w_active = 1'b0;
          if (!r_we)
            w_data_rd = wb_dat_i;
          w_state  = S_RELEASE;
        end else if (TMO_EN && r_tmo_cnt == TMO_LAST) begin
          w_abort = 1'b1;
        end else begin
          w_tmo_cnt = r_tmo_cnt + 16'd1;
        end
      end
      S_RETRY: begin
        w_cyc     = 1'b1;
        w_tmo_cnt = '0;
        w_state   = S_BUS;
      end
      S_RELEASE: begin
        if (!start)
          w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    if (w_abort) begin
      w_cyc       = 1'b0;
      w_active    = 1'b0;
      w_bus_error = 1'b1;
      w_err_addr  = r_adr;
      if (!r_we)
        w_data_rd = ERR_DATA;
      w_state     = S_RELEASE;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state     <= S_IDLE;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_active    <= 1'b0;
      r_data_rd   <= '0;
      r_rty_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_bus_error <= 1'b0;
      r_err_addr  <= '0;
    end else begin
      r_state     <= w_state;
      r_adr       <= w_adr;
      r_dat       <= w_dat;
      r_sel       <= w_sel;
      r_we        <= w_we;
      r_cyc       <= w_cyc;
      r_active    <= w_active;
      r_data_rd   <= w_data_rd;
      r_rty_cnt   <= w_rty_cnt;
      r_tmo_cnt   <= w_tmo_cnt;
      r_bus_error <= w_bus_error;
      r_err_addr  <= w_err_addr;
    end
  end

  assign data_rd   = r_data_rd;
  assign active    = r_active;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign wb_sel_o  = r_sel;
  assign wb_we_o   = r_we;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_cyc;
  assign bus_error = r_bus_error;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_dsp_wb_master.sv
// Directed bench for dsp_wb_master.
// Slave responses are driven cycle by cycle.
module tb_dsp_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic        start;
  logic [3:0]  selection;
  logic        write;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        active;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic        clear_error;
  logic        bus_error;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;

  dsp_wb_master #(
    .dw(32), .aw(32), .TIMEOUT(8), .MAX_RETRY(3),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .wb_clk(clk), .wb_rst(rst),
    .address(address), .start(start),
    .selection(selection), .write(write),
    .data_wr(data_wr), .data_rd(data_rd),
    .active(active),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .clear_error(clear_error),
    .bus_error(bus_error), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({wb_cyc_o, wb_stb_o, active, bus_error} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {wb_cyc_o, wb_stb_o, active, bus_error});
    end
    total++;
    if (data_rd !== 32'h0 || err_addr !== 32'h0
        || wb_adr_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_data rd=%h ea=%h adr=%h want=0",
               data_rd, err_addr, wb_adr_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read0();
    address = 32'h100; selection = 4'hF;
    write = 1'b0; start = 1'b1;
    tick();
    total++;
    if ({wb_cyc_o, wb_stb_o, active, wb_we_o} !== 4'b1110
        || wb_adr_o !== 32'h100 || wb_sel_o !== 4'hF) begin
      bad++;
      $display("FAIL rd0_issue cyc=%b act=%b adr=%h want 1 1 100",
               wb_cyc_o, active, wb_adr_o);
    end
    start = 1'b0;
    wb_dat_i = 32'h1234_5678; wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (wb_cyc_o !== 1'b0 || active !== 1'b0
        || data_rd !== 32'h1234_5678 || bus_error !== 1'b0) begin
      bad++;
      $display("FAIL rd0_done cyc=%b act=%b rd=%h be=%b want 0 0 12345678 0",
               wb_cyc_o, active, data_rd, bus_error);
    end
    tick();
  endtask

  task automatic test_write3();
    address = 32'h204; data_wr = 32'hA5A5_0000;
    selection = 4'hC; write = 1'b1; start = 1'b1;
    tick();
    address = 32'hFFF0; data_wr = 32'h1111_1111;
    selection = 4'h3; write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1
          || wb_adr_o !== 32'h204 || wb_dat_o !== 32'hA5A5_0000
          || wb_sel_o !== 4'hC || wb_we_o !== 1'b1) begin
        bad++;
        $display("FAIL wr3_hold%0d cyc=%b adr=%h dat=%h sel=%h we=%b",
                 i, wb_cyc_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o);
      end
      wb_ack_i = (i == 3);
      tick();
    end
    wb_ack_i = 1'b0;
    total++;
    if (wb_cyc_o !== 1'b0 || active !== 1'b0
        || data_rd !== 32'h1234_5678) begin
      bad++;
      $display("FAIL wr3_done cyc=%b act=%b rd=%h want 0 0 12345678",
               wb_cyc_o, active, data_rd);
    end
    tick();
    start = 1'b0;
    tick();
    tick();
    total++;
    if (wb_cyc_o !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("FAIL wr3_no_dup cyc=%b act=%b want 0 0",
               wb_cyc_o, active);
    end
  endtask

  task automatic test_retry();
    address = 32'h300; selection = 4'hF;
    write = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a < 2; a++) begin
      wb_rty_i = 1'b1;
      tick();
      wb_rty_i = 1'b0;
      total++;
      if (wb_cyc_o !== 1'b0 || active !== 1'b1) begin
        bad++;
        $display("FAIL rty_gap%0d cyc=%b act=%b want 0 1",
                 a, wb_cyc_o, active);
      end
      tick();
      total++;
      if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h300) begin
        bad++;
        $display("FAIL rty_reissue%0d cyc=%b adr=%h want 1 300",
                 a, wb_cyc_o, wb_adr_o);
      end
    end
    wb_dat_i = 32'h0000_CAFE; wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (data_rd !== 32'h0000_CAFE || active !== 1'b0
        || bus_error !== 1'b0) begin
      bad++;
      $display("FAIL rty_done rd=%h act=%b be=%b want 0000cafe 0 0",
               data_rd, active, bus_error);
    end
    tick();
  endtask

  task automatic test_retry_exhaust();
    int attempts;
    attempts = 0;
    address = 32'h400; write = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wb_rty_i = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (wb_cyc_o === 1'b1) attempts++;
      tick();
    end
    wb_rty_i = 1'b0;
    total++;
    if (attempts !== 4) begin
      bad++;
      $display("FAIL rtx_attempts got=%0d want=4", attempts);
    end
    total++;
    if (data_rd !== 32'hDEAD_BEEF || bus_error !== 1'b1
        || err_addr !== 32'h400 || active !== 1'b0) begin
      bad++;
      $display("FAIL rtx_abort rd=%h be=%b ea=%h act=%b",
               data_rd, bus_error, err_addr, active);
    end
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    total++;
    if (bus_error !== 1'b0) begin
      bad++;
      $display("FAIL rtx_clear be=%b want 0", bus_error);
    end
  endtask

  task automatic test_timeout();
    int hi;
    address = 32'h500; write = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    hi = (wb_cyc_o === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 8; k++) begin
      clear_error = (k == 8);
      tick();
      if (wb_cyc_o === 1'b1) hi++;
    end
    clear_error = 1'b0;
    total++;
    if (bus_error !== 1'b1 || err_addr !== 32'h500
        || data_rd !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL tmo_abort be=%b ea=%h rd=%h want 1 500 deadbeef",
               bus_error, err_addr, data_rd);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      if (wb_cyc_o === 1'b1) hi++;
    end
    total++;
    if (hi !== 8) begin
      bad++;
      $display("FAIL tmo_cycles got=%0d want=8", hi);
    end
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    total++;
    if (bus_error !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear be=%b want 0", bus_error);
    end
    address = 32'h600; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    wb_dat_i = 32'h0BAD_F00D; wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (data_rd !== 32'h0BAD_F00D || bus_error !== 1'b0) begin
      bad++;
      $display("FAIL tmo_after rd=%h be=%b want 0badf00d 0",
               data_rd, bus_error);
    end
    tick();
  endtask

  task automatic test_err();
    address = 32'h800; data_wr = 32'h7777_0000;
    write = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wb_err_i = 1'b1; wb_ack_i = 1'b1;
    tick();
    wb_err_i = 1'b0; wb_ack_i = 1'b0;
    total++;
    if (bus_error !== 1'b1 || err_addr !== 32'h800
        || data_rd !== 32'h0BAD_F00D || wb_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL err_abort be=%b ea=%h rd=%h cyc=%b",
               bus_error, err_addr, data_rd, wb_cyc_o);
    end
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    address = 32'h700; write = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({wb_cyc_o, wb_stb_o, active, bus_error} !== 4'b0
        || data_rd !== 32'h0) begin
      bad++;
      $display("FAIL rstmid flags=%b rd=%h want 0000 0",
               {wb_cyc_o, wb_stb_o, active, bus_error}, data_rd);
    end
    address = 32'h710; write = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 32'h710) begin
      bad++;
      $display("FAIL rstmid_issue cyc=%b adr=%h want 1 710",
               wb_cyc_o, wb_adr_o);
    end
    wb_dat_i = 32'h0000_55AA; wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    total++;
    if (data_rd !== 32'h0000_55AA || active !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_done rd=%h act=%b want 000055aa 0",
               data_rd, active);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; address = '0;
    selection = '0; write = 1'b0; data_wr = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0;
    wb_err_i = 1'b0; wb_rty_i = 1'b0;
    clear_error = 1'b0;
    #2;
    test_reset();
    test_read0();
    test_write3();
    test_retry();
    test_retry_exhaust();
    test_timeout();
    test_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
